// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit: operand latch, step counter,
// result capture and completion pulse. Define MULTDIV_CTRL_STATS_EN to add done/abort counters.
module multdiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 16,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_overflow,
    input  logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] opA_q,
    output logic [WIDTH-1:0] opB_q,
    output logic [31:0]      counter,
    output logic             mult_active,
    output logic             div_active,
    output logic             busy,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULTDIV_CTRL_STATS_EN
    ,
    output logic [15:0]      done_count,
    output logic [15:0]      abort_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES);
    localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES);

    state_t             state_r;
    state_t             next_state_s;
    logic               err_pend_r;
    logic               any_start_s;
    logic               one_start_s;
    logic               both_s;
    logic               div_zero_s;
    logic               mult_done_s;
    logic               div_done_s;
    logic               cap_s;
    logic [WIDTH-1:0]   cap_result_s;
    logic               cap_exc_s;

    assign any_start_s = ctrl_MULT | ctrl_DIV;
    assign one_start_s = ctrl_MULT ^ ctrl_DIV;
    assign both_s      = ctrl_MULT & ctrl_DIV;
    assign div_zero_s  = ctrl_DIV & ~ctrl_MULT & (data_operandB == {WIDTH{1'b0}});
    assign mult_done_s = (state_r == ST_MULT) && (counter == MULT_LAST);
    assign div_done_s  = (state_r == ST_DIV) && (counter == DIV_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: any start pulse overrides the running op
    always_comb begin
        next_state_s = state_r;
        if (both_s) begin
            next_state_s = ST_IDLE;
        end else if (ctrl_MULT) begin
            next_state_s = ST_MULT;
        end else if (ctrl_DIV) begin
            next_state_s = div_zero_s ? ST_IDLE : ST_DIV;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_IDLE;
                ST_MULT: next_state_s = mult_done_s ? ST_IDLE : ST_MULT;
                ST_DIV:  next_state_s = div_done_s ? ST_IDLE : ST_DIV;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Capture decode; a start on the same edge suppresses the finishing op's result
    always_comb begin
        cap_s        = 1'b0;
        cap_result_s = {WIDTH{1'b0}};
        cap_exc_s    = 1'b0;
        if (any_start_s) begin
            cap_s = 1'b0;
        end else if (err_pend_r) begin
            cap_s     = 1'b1;
            cap_exc_s = 1'b1;
        end else if (mult_done_s) begin
            cap_s        = 1'b1;
            cap_result_s = mult_result;
            cap_exc_s    = mult_overflow;
        end else if (div_done_s) begin
            cap_s        = 1'b1;
            cap_result_s = div_result;
        end else begin
            cap_s = 1'b0;
        end
    end

    // Operand latch, step counter, state decodes and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA_q          <= {WIDTH{1'b0}};
            opB_q          <= {WIDTH{1'b0}};
            counter        <= 32'd0;
            mult_active    <= 1'b0;
            div_active     <= 1'b0;
            busy           <= 1'b0;
            err_pend_r     <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            if (one_start_s) begin
                opA_q <= data_operandA;
                opB_q <= data_operandB;
            end
            if ((next_state_s != ST_IDLE) && !any_start_s) begin
                counter <= counter + 32'd1;
            end else begin
                counter <= 32'd0;
            end
            mult_active    <= (next_state_s == ST_MULT);
            div_active     <= (next_state_s == ST_DIV);
            busy           <= (next_state_s != ST_IDLE);
            err_pend_r     <= both_s | div_zero_s;
            data_resultRDY <= cap_s;
            if (cap_s) begin
                data_result    <= cap_result_s;
                data_exception <= cap_exc_s;
            end
        end
    end

`ifdef MULTDIV_CTRL_STATS_EN
    // Saturating completion and abort counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_count  <= 16'd0;
            abort_count <= 16'd0;
        end else begin
            if (cap_s && (done_count != 16'hFFFF)) begin
                done_count <= done_count + 16'd1;
            end
            if (any_start_s && (state_r != ST_IDLE) && (abort_count != 16'hFFFF)) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a behavioural multiply/divide datapath model.
module tb_multdiv_ctrl;

    logic        clk;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] mult_result;
    logic        mult_overflow;
    logic [31:0] div_result;
    logic [31:0] opA_q;
    logic [31:0] opB_q;
    logic [31:0] counter;
    logic        mult_active;
    logic        div_active;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_ctrl #(.WIDTH(32), .MULT_CYCLES(16), .DIV_CYCLES(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .mult_result    (mult_result),
        .mult_overflow  (mult_overflow),
        .div_result     (div_result),
        .opA_q          (opA_q),
        .opB_q          (opB_q),
        .counter        (counter),
        .mult_active    (mult_active),
        .div_active     (div_active),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: signed product/quotient of the latched operands
    logic signed [63:0] prod_s;
    always_comb begin
        prod_s        = $signed(opA_q) * $signed(opB_q);
        mult_result   = prod_s[31:0];
        mult_overflow = (prod_s != {{32{prod_s[31]}}, prod_s[31:0]});
        if (opB_q == 32'd0) begin
            div_result = 32'd0;
        end else begin
            div_result = $signed(opA_q) / $signed(opB_q);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        step();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Steps until RDY (bounded), counting latency, busy cycles and div_active sightings
    task automatic wait_rdy(output int lat, output int bcnt, output int dseen);
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        dseen = div_active ? 1 : 0;
        while (!data_resultRDY && lat < 100) begin
            step();
            lat++;
            if (busy) bcnt++;
            if (div_active) dseen = 1;
        end
    endtask

    int lat, bcnt, dseen, rdy_seen, busy_seen;

    initial begin
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        #1;
        chk("rst_counter", counter, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", data_result, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Multiply overflow
        start(1'b1, 1'b0, 32'h4000_0000, 32'd4);
        wait_rdy(lat, bcnt, dseen);
        chk("ovf_latency", lat, 32'd17);
        chk("ovf_result", data_result, 32'd0);
        chk("ovf_exc", {31'd0, data_exception}, 32'd1);

        // Plain multiply 7 * -3
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul_opA", opA_q, 32'd7);
        chk("mul_opB", opB_q, 32'hFFFF_FFFD);
        chk("mul_cnt0", counter, 32'd0);
        chk("mul_active", {31'd0, mult_active}, 32'd1);
        wait_rdy(lat, bcnt, dseen);
        chk("mul_latency", lat, 32'd17);
        chk("mul_busy_cycles", bcnt, 32'd17);
        chk("mul_result", data_result, 32'hFFFF_FFEB);
        chk("mul_exc", {31'd0, data_exception}, 32'd0);
        chk("mul_cnt_idle", counter, 32'd0);
        step();
        chk("mul_rdy_pulse", {31'd0, data_resultRDY}, 32'd0);
        chk("mul_hold", data_result, 32'hFFFF_FFEB);

        // Divide by zero
        start(1'b0, 1'b1, 32'd100, 32'd0);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        wait_rdy(lat, bcnt, dseen);
        chk("dz_latency", lat, 32'd1);
        chk("dz_result", data_result, 32'd0);
        chk("dz_exc", {31'd0, data_exception}, 32'd1);
        chk("dz_no_div_active", dseen, 32'd0);
        step();

        // Abort multiply at counter 5 with a divide 100 / 7
        start(1'b1, 1'b0, 32'd1, 32'd2);
        repeat (5) step();
        chk("abort_cnt5", counter, 32'd5);
        start(1'b0, 1'b1, 32'd100, 32'd7);
        chk("abort_cnt0", counter, 32'd0);
        chk("abort_div_active", {31'd0, div_active}, 32'd1);
        chk("abort_mult_inactive", {31'd0, mult_active}, 32'd0);
        wait_rdy(lat, bcnt, dseen);
        chk("abort_latency", lat, 32'd33);
        chk("abort_result", data_result, 32'd14);
        chk("abort_exc", {31'd0, data_exception}, 32'd0);
        step();

        // Start on the completion edge suppresses the old RDY
        start(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (16) step();
        chk("ce_cnt16", counter, 32'd16);
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("ce_no_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("ce_restart", counter, 32'd0);
        chk("ce_opA", opA_q, 32'd7);
        wait_rdy(lat, bcnt, dseen);
        chk("ce_latency", lat, 32'd17);
        chk("ce_result", data_result, 32'hFFFF_FFEB);
        step();

        // Simultaneous start pulses
        start(1'b1, 1'b1, 32'd9, 32'd9);
        chk("sim_rdy0", {31'd0, data_resultRDY}, 32'd0);
        chk("sim_busy", {31'd0, busy}, 32'd0);
        step();
        chk("sim_rdy1", {31'd0, data_resultRDY}, 32'd1);
        chk("sim_result", data_result, 32'd0);
        chk("sim_exc", {31'd0, data_exception}, 32'd1);
        chk("sim_idle", {30'd0, mult_active, div_active}, 32'd0);
        step();
        chk("sim_rdy_pulse", {31'd0, data_resultRDY}, 32'd0);

        // Reset in the middle of a divide
        start(1'b0, 1'b1, 32'd100, 32'd5);
        repeat (8) step();
        chk("rmid_cnt8", counter, 32'd8);
        #2 reset = 1'b1;
        #1;
        chk("rmid_counter", counter, 32'd0);
        chk("rmid_opA", opA_q, 32'd0);
        chk("rmid_active", {30'd0, mult_active, div_active}, 32'd0);
        chk("rmid_result", data_result, 32'd0);
        chk("rmid_exc", {31'd0, data_exception}, 32'd0);
        step();
        reset = 1'b0;
        rdy_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (data_resultRDY) rdy_seen++;
            if (busy) busy_seen++;
        end
        chk("rmid_no_rdy", rdy_seen, 32'd0);
        chk("rmid_no_busy", busy_seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller for the iterative multiply/divide unit.
- Accepts single-cycle ctrl_MULT / ctrl_DIV start pulses and latches operands.
- Drives the shared 32-bit step counter into the radix-4 Booth multiply datapath and the divide datapath, which load on counter==0 and advance one step per cycle.
- Captures the selected result, flags exceptions, and pulses data_resultRDY for the register-file writeback stage.

Parameters:
- WIDTH, 32, operand/result width.
- MULT_CYCLES, 16, radix-4 iterations for a WIDTH-bit multiply.
- DIV_CYCLES, 32, iterations for a WIDTH-bit divide.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- data_operandA  in  WIDTH  multiplicand / dividend
- data_operandB  in  WIDTH  multiplier / divisor
- mult_result  in  WIDTH  multiply datapath product
- mult_overflow  in  1  multiply datapath overflow
- div_result  in  WIDTH  divide datapath quotient
- opA_q  out  WIDTH  latched operand A to both datapaths
- opB_q  out  WIDTH  latched operand B to both datapaths
- counter  out  32  step counter to both datapaths
- mult_active  out  1  multiply in progress
- div_active  out  1  divide in progress
- busy  out  1  mult_active | div_active
- data_result  out  WIDTH  registered result
- data_exception  out  1  registered exception flag
- data_resultRDY  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including counter, opA_q, opB_q, data_result, data_exception and data_resultRDY.
- States and transitions:
  - IDLE: counter held at 0.
  - MULT
  - DIV
- Accept edge E0 (any state) with exactly one start pulse high:
  - latch data_operandA/B into opA_q/opB_q;
  - counter<=0;
  - state<=MULT or DIV.
- In MULT/DIV, counter increments by 1 each edge.
- MULT completion: at the edge where counter==MULT_CYCLES (edge E(MULT_CYCLES+1)):
  - data_result<=mult_result, data_exception<=mult_overflow;
  - data_resultRDY<=1 for one cycle;
  - state<=IDLE, counter<=0.
  - Latency from accept edge to RDY visible: MULT_CYCLES+1 = 17 cycles.
- DIV completion: same rule with DIV_CYCLES. data_result<=div_result, data_exception<=0. Latency 33 cycles.
- Divide by zero: ctrl_DIV with data_operandB==0.
  - State goes to IDLE directly; the datapath is not run.
  - At edge E1: data_result<=0, data_exception<=1, RDY pulse. Latency 1 cycle.
- ctrl_MULT and ctrl_DIV both high on the same edge (any state):
  - any running op is aborted, no operation starts, state<=IDLE;
  - next edge: data_result<=0, data_exception<=1, RDY pulse.
- Start pulse while busy: the current op is aborted with no RDY for it, and the new op restarts from counter 0 with the new operands.
- A start pulse on the same edge as a completion: the start wins, and the RDY for the finishing op is suppressed.
- data_result and data_exception hold their values until the next capture. data_resultRDY is 0 in every cycle except the single completion cycle.
- mult_active/div_active are registered state decodes; they are mutually exclusive.

Optional Feature:
- MULTDIV_CTRL_STATS_EN defined: adds output ports done_count[15:0] and abort_count[15:0].
  - Both are saturating counters, reset to 0.
  - done_count increments on every RDY pulse.
  - abort_count increments on every start that aborts a busy op.
- Undefined: these ports and their registers are absent. Core behaviour is identical in both builds.

Test Plan:
- Multiply: ctrl_MULT with A=7, B=-3 (0xFFFFFFFD), behavioural datapath model → RDY exactly 17 cycles after accept, data_result=0xFFFFFFEB, exception=0; busy high for 17 cycles.
- Multiply overflow: A=0x40000000, B=4 → RDY at 17 cycles, data_exception=1.
- Divide by zero: ctrl_DIV, A=100, B=0 → RDY 1 cycle after accept, result 0, exception 1, div_active never asserted.
- Abort: ctrl_MULT, then ctrl_DIV (A=100, B=7) when counter==5 → no RDY at cycle 17; RDY 33 cycles after the second accept with data_result=14; with STATS_EN, abort_count=1.
- Reset mid-op: assert reset at counter==8 of a divide → all outputs 0 immediately (before the next clk edge); no RDY after reset is released.
- Simultaneous starts: ctrl_MULT=ctrl_DIV=1 → next cycle RDY=1, result 0, exception 1, state IDLE.
